// File: rtl/pad_pattern_checker.sv
// Pad pattern checker: locks onto a +1 counter stream in the descrambled pad words
// and keeps saturating word / error-word / bit-error statistics for readout.
//
// state  | meaning
// HUNT   | no reference; next valid word seeds the expected counter
// VERIFY | seeded; counting consecutive matches towards lock
// LOCKED | locked; mismatches counted, consecutive misses drop lock
module pad_pattern_checker #(
    parameter int DATA_W   = 29,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] datain,
    input  logic              framein,
    input  logic              clear_cnt,
    output logic              locked,
    output logic              lock_lost,
    output logic              err_pulse,
    output logic [4:0]        err_bits,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_word_cnt,
    output logic [CNT_W-1:0]  bit_err_cnt
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [BAD_W-1:0]    bad_cnt_q, bad_cnt_d;
    logic                locked_q, locked_d;
    logic                lock_lost_q, lock_lost_d;
    logic                err_pulse_q, err_pulse_d;
    logic [4:0]          err_bits_q, err_bits_d;
    logic                word_inc_q, word_inc_d;
    logic                err_inc_q, err_inc_d;
    logic [4:0]          bits_inc_q, bits_inc_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]    err_word_cnt_q, err_word_cnt_d;
    logic [CNT_W-1:0]    bit_err_cnt_q, bit_err_cnt_d;

    logic [DATA_W-1:0]   diff;
    logic [4:0]          err_pop;
    logic                match;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [5:0]       b);
        logic [CNT_W+5:0] s;
        s = {6'd0, a} + {{CNT_W{1'b0}}, b};
        if (s > {6'd0, {CNT_W{1'b1}}})
            return {CNT_W{1'b1}};
        return s[CNT_W-1:0];
    endfunction

    always_comb begin
        diff    = datain ^ exp_q;
        match   = (diff == '0);
        err_pop = '0;
        for (int i = 0; i < DATA_W; i++)
            err_pop = err_pop + {4'd0, diff[i]};
    end

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        lock_lost_d = 1'b0;
        err_pulse_d = 1'b0;
        err_bits_d  = '0;
        word_inc_d  = 1'b0;
        err_inc_d   = 1'b0;
        bits_inc_d  = '0;

        if (framein) begin
            case (state_q)
                HUNT: begin
                    exp_d      = datain + 1'b1;
                    good_cnt_d = GOOD_W'(1);
                    state_d    = VERIFY;
                end
                VERIFY: begin
                    if (match) begin
                        exp_d      = exp_q + 1'b1;
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state_d   = LOCKED;
                            bad_cnt_d = '0;
                        end
                    end else begin
                        exp_d      = datain + 1'b1;
                        good_cnt_d = GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    // The reference keeps counting through errors; it never reseeds here.
                    exp_d      = exp_q + 1'b1;
                    word_inc_d = 1'b1;
                    if (match) begin
                        bad_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_bits_d  = err_pop;
                        err_inc_d   = 1'b1;
                        bits_inc_d  = err_pop;
                        bad_cnt_d   = bad_cnt_q + 1'b1;
                        if (bad_cnt_q == BAD_W'(LOSS_CNT - 1)) begin
                            state_d     = HUNT;
                            lock_lost_d = 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // A clear also discards the increment latched alongside it, so it wins outright.
        if (clear_cnt) begin
            word_inc_d = 1'b0;
            err_inc_d  = 1'b0;
            bits_inc_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_comb begin
        if (clear_cnt) begin
            word_cnt_d     = '0;
            err_word_cnt_d = '0;
            bit_err_cnt_d  = '0;
        end else begin
            word_cnt_d     = sat_add(word_cnt_q, {5'd0, word_inc_q});
            err_word_cnt_d = sat_add(err_word_cnt_q, {5'd0, err_inc_q});
            bit_err_cnt_d  = sat_add(bit_err_cnt_q, {1'b0, bits_inc_q});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HUNT;
            exp_q          <= '0;
            good_cnt_q     <= '0;
            bad_cnt_q      <= '0;
            locked_q       <= 1'b0;
            lock_lost_q    <= 1'b0;
            err_pulse_q    <= 1'b0;
            err_bits_q     <= '0;
            word_inc_q     <= 1'b0;
            err_inc_q      <= 1'b0;
            bits_inc_q     <= '0;
            word_cnt_q     <= '0;
            err_word_cnt_q <= '0;
            bit_err_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            exp_q          <= exp_d;
            good_cnt_q     <= good_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            locked_q       <= locked_d;
            lock_lost_q    <= lock_lost_d;
            err_pulse_q    <= err_pulse_d;
            err_bits_q     <= err_bits_d;
            word_inc_q     <= word_inc_d;
            err_inc_q      <= err_inc_d;
            bits_inc_q     <= bits_inc_d;
            word_cnt_q     <= word_cnt_d;
            err_word_cnt_q <= err_word_cnt_d;
            bit_err_cnt_q  <= bit_err_cnt_d;
        end
    end

    assign locked       = locked_q;
    assign lock_lost    = lock_lost_q;
    assign err_pulse    = err_pulse_q;
    assign err_bits     = err_bits_q;
    assign word_cnt     = word_cnt_q;
    assign err_word_cnt = err_word_cnt_q;
    assign bit_err_cnt  = bit_err_cnt_q;

endmodule

// File: tb/tb_pad_pattern_checker.sv
// Directed bench for pad_pattern_checker: a behavioural model pushes expected outputs
// per driven word into a scoreboard, popped and asserted one edge later.
module tb_pad_pattern_checker;

    localparam int DW   = 29;
    localparam int CW   = 5;
    localparam int LK   = 8;
    localparam int LS   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] datain;
    logic          framein;
    logic          clear_cnt;
    logic          locked;
    logic          lock_lost;
    logic          err_pulse;
    logic [4:0]    err_bits;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] err_word_cnt;
    logic [CW-1:0] bit_err_cnt;

    pad_pattern_checker #(
        .DATA_W  (DW),
        .LOCK_CNT(LK),
        .LOSS_CNT(LS),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .datain      (datain),
        .framein     (framein),
        .clear_cnt   (clear_cnt),
        .locked      (locked),
        .lock_lost   (lock_lost),
        .err_pulse   (err_pulse),
        .err_bits    (err_bits),
        .word_cnt    (word_cnt),
        .err_word_cnt(err_word_cnt),
        .bit_err_cnt (bit_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          lk;
        logic          ll;
        logic          ep;
        logic [4:0]    eb;
        logic [CW-1:0] wc;
        logic [CW-1:0] ewc;
        logic [CW-1:0] bec;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // reference model state
    int          m_state;
    logic [DW-1:0] m_exp;
    int          m_good, m_bad;
    int          m_wc, m_ewc, m_bec;
    int          p_w, p_e, p_b;

    function automatic int popc(input logic [DW-1:0] v);
        int c = 0;
        for (int i = 0; i < DW; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int sat(input int a);
        return (a > CMAX) ? CMAX : a;
    endfunction

    task automatic model_reset();
        m_state = 0; m_exp = '0; m_good = 0; m_bad = 0;
        m_wc = 0; m_ewc = 0; m_bec = 0;
        p_w = 0; p_e = 0; p_b = 0;
    endtask

    task automatic model_step(input logic f, input logic [DW-1:0] d, input logic clr,
                              output exp_t e);
        int nw = 0, ne = 0, nb = 0, ll = 0;
        if (clr) begin
            m_wc = 0; m_ewc = 0; m_bec = 0;
        end else begin
            m_wc  = sat(m_wc + p_w);
            m_ewc = sat(m_ewc + p_e);
            m_bec = sat(m_bec + p_b);
        end
        if (f) begin
            case (m_state)
                0: begin
                    m_exp = d + 1'b1; m_good = 1; m_state = 1;
                end
                1: begin
                    if (d == m_exp) begin
                        m_exp = m_exp + 1'b1;
                        if (m_good == LK - 1) begin m_state = 2; m_bad = 0; end
                        m_good++;
                    end else begin
                        m_exp = d + 1'b1; m_good = 1;
                    end
                end
                default: begin
                    nw = 1;
                    if (d == m_exp) m_bad = 0;
                    else begin
                        ne = 1; nb = popc(d ^ m_exp); m_bad++;
                        if (m_bad == LS) begin m_state = 0; ll = 1; end
                    end
                    m_exp = m_exp + 1'b1;
                end
            endcase
        end
        p_w = clr ? 0 : nw;
        p_e = clr ? 0 : ne;
        p_b = clr ? 0 : nb;
        e.lk  = (m_state == 2);
        e.ll  = ll[0];
        e.ep  = ne[0];
        e.eb  = 5'(nb);
        e.wc  = CW'(m_wc);
        e.ewc = CW'(m_ewc);
        e.bec = CW'(m_bec);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("locked",       32'(locked),       32'(e.lk));
            chk("lock_lost",    32'(lock_lost),    32'(e.ll));
            chk("err_pulse",    32'(err_pulse),    32'(e.ep));
            chk("err_bits",     32'(err_bits),     32'(e.eb));
            chk("word_cnt",     32'(word_cnt),     32'(e.wc));
            chk("err_word_cnt", 32'(err_word_cnt), 32'(e.ewc));
            chk("bit_err_cnt",  32'(bit_err_cnt),  32'(e.bec));
        end
    endtask

    task automatic drive(input logic f, input logic [DW-1:0] d, input logic clr);
        exp_t e;
        datain    = d;
        framein   = f;
        clear_cnt = clr;
        model_step(f, d, clr, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"},       32'(locked),       32'd0);
        chk({tag, "_lock_lost"},    32'(lock_lost),    32'd0);
        chk({tag, "_err_pulse"},    32'(err_pulse),    32'd0);
        chk({tag, "_err_bits"},     32'(err_bits),     32'd0);
        chk({tag, "_word_cnt"},     32'(word_cnt),     32'd0);
        chk({tag, "_err_word_cnt"}, 32'(err_word_cnt), 32'd0);
        chk({tag, "_bit_err_cnt"},  32'(bit_err_cnt),  32'd0);
    endtask

    task automatic reset_mid();
        framein   = 1'b0;
        clear_cnt = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        model_reset();
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero("rst_rel");
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n     = 1'b0;
        framein   = 1'b0;
        clear_cnt = 1'b0;
        datain    = '0;
        model_reset();
        #1;
        check_zero("rst");
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1) lock on 0x100..0x107
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t1_pre_lock", 32'(locked), 32'd0);
            drive(1'b1, DW'(32'h100 + i), 1'b0);
        end
        chk("t1_locked", 32'(locked), 32'd1);
        chk("t1_word_cnt", 32'(word_cnt), 32'd0);

        // 2) single 3-bit error at 0x200
        for (int v = 32'h108; v < 32'h200; v++) drive(1'b1, DW'(v), 1'b0);
        drive(1'b0, '0, 1'b1);
        drive(1'b1, DW'(32'h200 ^ 32'h7), 1'b0);
        chk("t2_err_pulse", 32'(err_pulse), 32'd1);
        chk("t2_err_bits", 32'(err_bits), 32'd3);
        drive(1'b1, DW'(32'h201), 1'b0);
        chk("t2_pulse_end", 32'(err_pulse), 32'd0);
        chk("t2_err_word_cnt", 32'(err_word_cnt), 32'd1);
        chk("t2_bit_err_cnt", 32'(bit_err_cnt), 32'd3);
        chk("t2_locked", 32'(locked), 32'd1);
        drive(1'b1, DW'(32'h202), 1'b0);

        // 3) four consecutive bad words drop lock
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) drive(1'b1, DW'((32'h203 + i) ^ 32'h10), 1'b0);
        chk("t3_lock_lost", 32'(lock_lost), 32'd1);
        chk("t3_locked", 32'(locked), 32'd0);
        drive(1'b0, '0, 1'b0);
        chk("t3_lost_end", 32'(lock_lost), 32'd0);
        chk("t3_err_word_cnt", 32'(err_word_cnt), 32'd4);
        chk("t3_word_cnt", 32'(word_cnt), 32'd4);

        // 4) lock just below the wrap and keep counting across it
        for (int i = 0; i < 8; i++) drive(1'b1, DW'(32'h1FFF_FFF8 + i), 1'b0);
        chk("t4_locked", 32'(locked), 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, DW'(i), 1'b0);
        drive(1'b0, '0, 1'b0);
        chk("t4_word_cnt", 32'(word_cnt), 32'd7);
        chk("t4_err_word_cnt", 32'(err_word_cnt), 32'd4);

        // 5) saturation, then clear colliding with an error
        d = DW'(3);
        drive(1'b1, d, 1'b1);
        d = d + 1'b1;
        for (int k = 0; k < CMAX + 2; k++) begin
            drive(1'b1, d ^ DW'(1), 1'b0);
            d = d + 1'b1;
            drive(1'b1, d, 1'b0);
            d = d + 1'b1;
        end
        chk("t5_err_word_sat", 32'(err_word_cnt), 32'(CMAX));
        chk("t5_bit_err_sat", 32'(bit_err_cnt), 32'(CMAX));
        chk("t5_word_sat", 32'(word_cnt), 32'(CMAX));
        drive(1'b1, d ^ DW'(3), 1'b1);
        d = d + 1'b1;
        chk("t5_clr_err_pulse", 32'(err_pulse), 32'd1);
        chk("t5_clr_err_bits", 32'(err_bits), 32'd2);
        drive(1'b0, '0, 1'b0);
        chk("t5_clr_err_word", 32'(err_word_cnt), 32'd0);
        chk("t5_clr_bit_err", 32'(bit_err_cnt), 32'd0);
        chk("t5_locked", 32'(locked), 32'd1);

        // 6) reset while locked, then lock with framing gaps
        reset_mid();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(32'h5000 + i), 1'b0);
            drive(1'b0, DW'($urandom), 1'b0);
        end
        chk("t6_locked_gaps", 32'(locked), 32'd1);
        for (int i = 8; i < 11; i++) drive(1'b1, DW'(32'h5000 + i), 1'b0);
        reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
